// File: rtl/alu_pkg.sv
// Shared opcodes, flag layout and arbiter state encoding for the ALU-sharing block.
package alu_pkg;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry_out;
    } alu_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU. Subtract reports carry_out as "no borrow" (A >= B unsigned);
// reserved opcodes yield a zero result.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       cntrl_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = '0;
        result_o = '0;
        flags_o  = '0;
        case (cntrl_i)
            ALU_PASSB: result_o = b_i;
            ALU_ADD: begin
                sum               = {1'b0, a_i} + {1'b0, b_i};
                result_o          = sum[WIDTH-1:0];
                flags_o.carry_out = sum[WIDTH];
                flags_o.overflow  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                sum               = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                result_o          = sum[WIDTH-1:0];
                flags_o.carry_out = sum[WIDTH];
                flags_o.overflow  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
        flags_o.negative = result_o[WIDTH-1];
        flags_o.zero     = (result_o == '0);
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the priority pointer flips away from whichever port was granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic prio_q, prio_d;

    always_comb begin
        grant  = '0;
        prio_d = prio_q;
        if (en && (|req)) begin
            if (req[prio_q]) grant[prio_q]  = 1'b1;
            else             grant[~prio_q] = 1'b1;
            prio_d = ~grant[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prio_q <= 1'b0;
        else          prio_q <= prio_d;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-multiplexes one ALU between the PC adder (port 0) and execute operands (port 1),
// one op in flight, with a registered per-port-tagged response.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREQ  = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_A,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_B,
    input  logic [NREQ-1:0][2:0]        req_cntrl,
    output logic                        rsp_valid,
    output logic                        rsp_id,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_result,
    output logic [3:0]                  rsp_flags
);

    arb_state_e       state_q, state_d;
    logic             can_issue;
    logic [NREQ-1:0]  grant;
    logic             gid;
    logic [WIDTH-1:0] alu_result;
    alu_flags_t       alu_flags;
    logic [WIDTH-1:0] rsp_result_q;
    alu_flags_t       rsp_flags_q;
    logic             rsp_id_q;

    // Draining the held response frees the slot for a same-cycle refill.
    assign can_issue = (state_q == IDLE) || rsp_ready;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .en      (can_issue),
        .grant   (grant)
    );

    assign req_ready = reset_n ? grant : '0;
    assign gid       = grant[1];

    alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (req_A[gid]),
        .b_i      (req_B[gid]),
        .cntrl_i  (req_cntrl[gid]),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    always_comb begin
        state_d = state_q;
        if (|grant)         state_d = HOLD;
        else if (rsp_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (|grant) begin
                rsp_result_q <= alu_result;
                rsp_flags_q  <= alu_flags;
                rsp_id_q     <= gid;
            end
        end
    end

    assign rsp_valid  = (state_q == HOLD);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus random check of the shared-ALU arbiter against a transaction-level model.
module tb_alu_share_arbiter;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][63:0] req_A;
    logic [1:0][63:0] req_B;
    logic [1:0][2:0]  req_cntrl;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic [3:0]       rsp_flags;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(64), .NREQ(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_cntrl  (req_cntrl),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    int n_chk = 0;
    int n_err = 0;

    // pending request per port (requester holds it until accepted)
    bit          pv [2];
    logic [63:0] pa [2];
    logic [63:0] pb [2];
    logic [2:0]  pc [2];

    // model of the response slot and fairness pointer
    bit          m_valid;
    bit          m_id;
    logic [63:0] m_res;
    logic [3:0]  m_flg;
    bit          m_prio;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns {negative, zero, overflow, carry_out, result}
    function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c);
        logic [63:0] r = 64'd0;
        bit cy = 0, ov = 0;
        case (c)
            3'b000: r = b;
            3'b010: begin
                r  = a + b;
                cy = (r < a);
                ov = ($signed(a) >= 0 && $signed(b) >= 0 && $signed(r) < 0) ||
                     ($signed(a) <  0 && $signed(b) <  0 && $signed(r) >= 0);
            end
            3'b011: begin
                r  = a - b;
                cy = (a >= b);
                ov = ($signed(a) >= 0 && $signed(b) <  0 && $signed(r) < 0) ||
                     ($signed(a) <  0 && $signed(b) >= 0 && $signed(r) >= 0);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = 64'd0;
        endcase
        return {r[63], (r == 64'd0), ov, cy, r};
    endfunction

    task automatic set_op(input int p, input logic [63:0] a, input logic [63:0] b, input logic [2:0] c);
        if (!pv[p]) begin
            pv[p] = 1; pa[p] = a; pb[p] = b; pc[p] = c;
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return {$urandom, $urandom};
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return 64'($urandom_range(0, 15));
        endcase
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit rr);
        bit can, any, g;
        logic [1:0] exp_rdy;
        logic [67:0] ref_out;
        rsp_ready = rr;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = pv[i];
            req_A[i] = pa[i]; req_B[i] = pb[i]; req_cntrl[i] = pc[i];
        end
        #1;
        can = !m_valid || rr;
        any = pv[0] || pv[1];
        g   = pv[m_prio] ? m_prio : !m_prio;
        exp_rdy = 2'b00;
        if (can && any) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (can && any) begin
            ref_out = ref_alu(pa[g], pb[g], pc[g]);
            m_valid = 1; m_id = g; m_res = ref_out[63:0]; m_flg = ref_out[67:64];
            m_prio  = !g;
            pv[g]   = 0;
        end else if (rr) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        if (m_valid) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flags", 64'(rsp_flags), 64'(m_flg));
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_A = '0; req_B = '0; req_cntrl = '0;
        for (int i = 0; i < 2; i++) begin pv[i] = 0; pa[i] = '0; pb[i] = '0; pc[i] = '0; end
        m_valid = 0; m_id = 0; m_res = '0; m_flg = '0; m_prio = 0;

        // reset holds everything off even with both ports requesting
        set_op(0, 64'd5, 64'd7, 3'b010);
        set_op(1, 64'd3, 64'd3, 3'b011);
        req_valid = 2'b11; rsp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // contention: port 0 first, then alternate; port1 sub 3-3 gives zero
        cycle(1);
        set_op(0, 64'd10, 64'd20, 3'b010);
        cycle(1);
        set_op(1, 64'hAA, 64'h0F, 3'b100);
        cycle(1);
        cycle(1);
        cycle(1);

        // backpressure: held xor result, nothing accepted until rsp_ready rises
        set_op(1, 64'hFF, 64'h0F, 3'b110);
        cycle(1);
        set_op(0, 64'd1, 64'd2, 3'b010);
        repeat (3) cycle(0);
        cycle(1);
        cycle(1);

        // wrap and signed overflow
        set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        cycle(1);
        set_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        cycle(1);
        set_op(1, 64'd0, 64'd1, 3'b011);
        cycle(1);
        cycle(1);

        // randomized traffic, all opcodes including reserved ones
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(0, 9) < 6)
                    set_op(p, rnd64(), rnd64(), 3'($urandom_range(0, 7)));
            cycle($urandom_range(0, 3) != 0);
        end

        // reset pulse while a response is held; prio left at 1 beforehand
        pv[0] = 0; pv[1] = 0;
        cycle(1);
        set_op(0, 64'd9, 64'd9, 3'b010);
        cycle(0);
        #2 reset_n = 1'b0;
        pv[0] = 0; pv[1] = 0; req_valid = '0;
        m_valid = 0; m_prio = 0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_result", rsp_result, 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        set_op(1, 64'd4, 64'd1, 3'b011);
        set_op(0, 64'd4, 64'd1, 3'b101);
        cycle(1);
        cycle(1);
        cycle(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
